if_id_skid_buffer: RTL and testbench



---
 rtl/if_id_skid_buffer.sv | 143 ++++++++++++++
 tb/tb_if_id_skid_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_buffer.sv
// IF/ID boundary: 2-entry skid buffer between fetch and decode, exposing decoded MIPS fields.
// Optional stall counter output enabled by defining IFID_STALL_CNT_EN.
module if_id_skid_buffer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [PC_W-1:0] out_pc_plus4,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
`ifdef IFID_STALL_CNT_EN
    output logic [31:0]     stall_cnt,
`endif
    output logic [15:0]     imm16
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [31:0]     head_instr;
    logic [PC_W-1:0] head_pc;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            accept;
    logic            pop;
    logic            load_head;
    logic            load_skid;
    logic            skid_to_head;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        next_state   = state;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state = ONE;
                        load_head  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        next_state = FULL;
                        load_skid  = 1'b1;
                    end else if (pop) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        next_state   = ONE;
                        skid_to_head = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // in_ready is a flop fed from next_state so decode's out_ready never reaches fetch combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_instr <= '0;
            head_pc    <= RESET_PC;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            if (load_head) begin
                head_instr <= in_instr;
                head_pc    <= in_pc;
            end else if (skid_to_head) begin
                head_instr <= skid_instr;
                head_pc    <= skid_pc;
            end
            if (load_skid) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
            end
        end
    end

    // Data is left in place on pop; an empty buffer shows a NOP but keeps the last PC.
    assign out_instr    = out_valid ? head_instr : 32'h0000_0000;
    assign out_pc       = head_pc;
    assign out_pc_plus4 = head_pc + PC_W'(4);
    assign opcode       = out_instr[31:26];
    assign rs           = out_instr[25:21];
    assign rt           = out_instr[20:16];
    assign rd           = out_instr[15:11];
    assign shamt        = out_instr[10:6];
    assign funct        = out_instr[5:0];
    assign imm16        = out_instr[15:0];

`ifdef IFID_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Self-checking bench for if_id_skid_buffer: vector table with explicit expectations plus a FIFO scoreboard.
// Hand-written sequences cover streaming, async reset while full and the optional stall counter.
module tb_if_id_skid_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        f;
        logic        ordy;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    vec_t   vecs[22];
    entry_t sb[$];
    int     n_vectors;
    int     n_miscompares;
    int     n_pops;

    if_id_skid_buffer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
`ifdef IFID_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .imm16        (imm16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic f, input logic ordy);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        flush     = f;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called once per cycle away from the edge: checks occupancy, then retires pops and records accepts.
    task automatic scoreboardStep();
        entry_t      e;
        logic [31:0] ei;
        logic        acc;
        logic        pp;
        checkOutput("sb_out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
        checkOutput("sb_in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
        if (!out_valid) checkOutput("sb_empty_nop", out_instr, 32'h0);
        acc = in_valid & in_ready;
        pp  = out_valid & out_ready;
        if (flush) begin
            sb.delete();
        end else begin
            if (pp) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_pop_unexpected", {31'd0, pp}, 32'd0);
                end else begin
                    e  = sb.pop_front();
                    ei = e.instr;
                    n_pops++;
                    checkOutput("sb_instr", out_instr, ei);
                    checkOutput("sb_pc", out_pc, e.pc);
                    checkOutput("sb_pc_plus4", out_pc_plus4, e.pc + 32'd4);
                    checkOutput("sb_opcode", {26'd0, opcode}, {26'd0, ei[31:26]});
                    checkOutput("sb_rs", {27'd0, rs}, {27'd0, ei[25:21]});
                    checkOutput("sb_rt", {27'd0, rt}, {27'd0, ei[20:16]});
                    checkOutput("sb_rd", {27'd0, rd}, {27'd0, ei[15:11]});
                    checkOutput("sb_shamt", {27'd0, shamt}, {27'd0, ei[10:6]});
                    checkOutput("sb_funct", {26'd0, funct}, {26'd0, ei[5:0]});
                    checkOutput("sb_imm16", {16'd0, imm16}, {16'd0, ei[15:0]});
                end
            end
            if (acc) begin
                e.instr = in_instr;
                e.pc    = in_pc;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        int          start_pops;
        logic [31:0] wrap_sum;
        n_vectors     = 0;
        n_miscompares = 0;
        n_pops        = 0;

        //            v     instr          pc            f     ordy  ov    ir    exp_instr      exp_pc
        vecs[0]  = '{1'b1, 32'h2008_FFFC, 32'h0040_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h2008_FFFC, 32'h0040_0000};
        vecs[2]  = '{1'b1, 32'h8C48_0004, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0040_0000};
        vecs[3]  = '{1'b1, 32'h0109_5020, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8C48_0004, 32'h0000_0100};
        vecs[4]  = '{1'b1, 32'h0011_2080, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8C48_0004, 32'h0000_0100};
        vecs[5]  = '{1'b1, 32'h0011_2080, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8C48_0004, 32'h0000_0100};
        vecs[6]  = '{1'b1, 32'h0011_2080, 32'h0000_0108, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8C48_0004, 32'h0000_0100};
        vecs[7]  = '{1'b1, 32'h0011_2080, 32'h0000_0108, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0109_5020, 32'h0000_0104};
        vecs[8]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0011_2080, 32'h0000_0108};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0000_0108};
        vecs[10] = '{1'b1, 32'h1000_0003, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0000_0108};
        vecs[11] = '{1'b1, 32'hAC48_0008, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0003, 32'h0000_0200};
        vecs[12] = '{1'b1, 32'h0800_0100, 32'h0000_0208, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0003, 32'h0000_0200};
        vecs[13] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0200};
        vecs[14] = '{1'b1, 32'h2129_0001, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0200};
        vecs[15] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0200};
        vecs[16] = '{1'b1, 32'h3C01_1234, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0200};
        vecs[17] = '{1'b1, 32'h3421_5678, 32'h0000_0404, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3C01_1234, 32'h0000_0400};
        vecs[18] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0000_0400};
        vecs[19] = '{1'b1, 32'h03E0_0008, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0400};
        vecs[20] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h03E0_0008, 32'hFFFF_FFFC};
        vecs[21] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hFFFF_FFFC};

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_instr", out_instr, 32'h0);
        checkOutput("reset_out_pc", out_pc, 32'h0);
        checkOutput("reset_out_pc_plus4", out_pc_plus4, 32'h4);
`ifdef IFID_STALL_CNT_EN
        checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].f, vecs[i].ordy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            checkOutput($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
            checkOutput($sformatf("vec%0d_out_instr", i), out_instr, vecs[i].exp_instr);
            checkOutput($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
            wrap_sum = vecs[i].exp_pc + 32'd4;
            checkOutput($sformatf("vec%0d_pc_plus4", i), out_pc_plus4, wrap_sum);
            if (i == 1) begin
                checkOutput("addi_opcode", {26'd0, opcode}, 32'h08);
                checkOutput("addi_rs", {27'd0, rs}, 32'd0);
                checkOutput("addi_rt", {27'd0, rt}, 32'd8);
                checkOutput("addi_imm16", {16'd0, imm16}, 32'hFFFC);
                checkOutput("addi_pc_plus4", out_pc_plus4, 32'h0040_0004);
            end
            if (i == 20) checkOutput("wrap_pc_plus4", out_pc_plus4, 32'h0000_0000);
            scoreboardStep();
            @(posedge clk);
            #1;
        end

        // Full-rate streaming: one transfer per cycle, ready never drops.
        start_pops = n_pops;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) applyStimulus(1'b1, $urandom, 32'h0000_1000 + 32'(k * 4), 1'b0, 1'b1);
            else       applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            scoreboardStep();
            @(posedge clk);
            #1;
        end
        checkOutput("stream_count", n_pops - start_pops, 32'd8);

        // Fill to FULL, then pulse reset between clock edges.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 32'hDEAD_0000 + 32'(k), 32'h0000_0500 + 32'(k * 4), 1'b0, 1'b0);
            @(negedge clk);
            scoreboardStep();
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        scoreboardStep();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("async_out_instr", out_instr, 32'h0);
        checkOutput("async_out_pc", out_pc, 32'h0);
        checkOutput("async_out_pc_plus4", out_pc_plus4, 32'h4);
        #1 rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;

`ifdef IFID_STALL_CNT_EN
        applyStimulus(1'b1, 32'h2402_000A, 32'h0000_0600, 1'b0, 1'b0);
        @(negedge clk);
        scoreboardStep();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            scoreboardStep();
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("stall_cnt_five", stall_cnt, 32'd5);
        scoreboardStep();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_cnt_after_flush", stall_cnt, 32'd5);
        scoreboardStep();
        @(posedge clk);
        #1;
`else
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        scoreboardStep();
        @(posedge clk);
        #1;
`endif

        checkOutput("final_sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
